// File: rtl/pipe_ctrl_unit.sv
// Main control for the 5-stage MIPS pipe: opcode decode, ID/EX-EX/MEM-MEM/WB control regs, hazard/flush steering.
// Latency: decode on ex_* after 1 cycle, mem_* after 2, wb_wb after 3; pc/ifid steering is combinational.
// Backpressure: load-use stalls hold PC and IF/ID for one cycle; taken branches and jumps flush IF/ID.
module pipe_ctrl_unit #(
    parameter int REG_AW  = 5,
    parameter bit EN_ADDI = 1'b1,
    parameter bit EN_JUMP = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              mem_zero,
    output logic [1:0]        ex_wb,
    output logic [2:0]        ex_m,
    output logic [3:0]        ex_ex,
    output logic [REG_AW-1:0] ex_rt,
    output logic [1:0]        mem_wb,
    output logic [2:0]        mem_m,
    output logic [1:0]        wb_wb,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [1:0]        pc_src,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JMP = 2'b10;

    logic [1:0]        dec_wb;
    logic [2:0]        dec_m;
    logic [3:0]        dec_ex;
    logic              dec_ill;

    logic [1:0]        ex_wb_q,  ex_wb_d;
    logic [2:0]        ex_m_q,   ex_m_d;
    logic [3:0]        ex_ex_q,  ex_ex_d;
    logic [REG_AW-1:0] ex_rt_q,  ex_rt_d;
    logic [1:0]        mem_wb_q, mem_wb_d;
    logic [2:0]        mem_m_q,  mem_m_d;
    logic [1:0]        wb_wb_q,  wb_wb_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic br_taken;
    logic jmp;
    logic stall_inc;
    logic flush_inc;

    // Unlisted or disabled opcodes decode to all-zero controls and behave as a NOP.
    always_comb begin
        dec_wb  = 2'b00;
        dec_m   = 3'b000;
        dec_ex  = 4'b0000;
        dec_ill = 1'b1;
        case (id_opcode)
            OP_R: begin
                dec_wb  = 2'b10;
                dec_ex  = 4'b1100;
                dec_ill = 1'b0;
            end
            OP_LW: begin
                dec_wb  = 2'b11;
                dec_m   = 3'b010;
                dec_ex  = 4'b0001;
                dec_ill = 1'b0;
            end
            OP_SW: begin
                dec_m   = 3'b001;
                dec_ex  = 4'b0001;
                dec_ill = 1'b0;
            end
            OP_BEQ: begin
                dec_m   = 3'b100;
                dec_ex  = 4'b0010;
                dec_ill = 1'b0;
            end
            OP_ADDI: begin
                if (EN_ADDI) begin
                    dec_wb  = 2'b10;
                    dec_ex  = 4'b0001;
                    dec_ill = 1'b0;
                end
            end
            OP_J: begin
                dec_ill = !EN_JUMP;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    assign load_use = ex_m_q[1] && (ex_rt_q != '0) &&
                      ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
    assign br_taken = mem_m_q[2] && mem_zero;
    assign jmp      = EN_JUMP && (id_opcode == OP_J);

    // A taken branch pre-empts both the stall and the jump, so each cycle bumps at most one counter.
    assign stall_inc = !br_taken && load_use;
    assign flush_inc = br_taken || (!load_use && jmp);

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pc_src     = SRC_SEQ;
        if (rst_n) begin
            if (br_taken) begin
                ifid_flush = 1'b1;
                pc_src     = SRC_BR;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else if (jmp) begin
                ifid_flush = 1'b1;
                pc_src     = SRC_JMP;
            end
        end
    end

    always_comb begin
        ex_wb_d  = dec_wb;
        ex_m_d   = dec_m;
        ex_ex_d  = dec_ex;
        ex_rt_d  = id_rt;
        mem_wb_d = ex_wb_q;
        mem_m_d  = ex_m_q;
        wb_wb_d  = mem_wb_q;
        if (br_taken) begin
            ex_wb_d  = 2'b00;
            ex_m_d   = 3'b000;
            ex_ex_d  = 4'b0000;
            ex_rt_d  = '0;
            mem_wb_d = 2'b00;
            mem_m_d  = 3'b000;
        end else if (load_use) begin
            ex_wb_d  = 2'b00;
            ex_m_d   = 3'b000;
            ex_ex_d  = 4'b0000;
            ex_rt_d  = '0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_wb_q     <= 2'b00;
            ex_m_q      <= 3'b000;
            ex_ex_q     <= 4'b0000;
            ex_rt_q     <= '0;
            mem_wb_q    <= 2'b00;
            mem_m_q     <= 3'b000;
            wb_wb_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_wb_q     <= ex_wb_d;
            ex_m_q      <= ex_m_d;
            ex_ex_q     <= ex_ex_d;
            ex_rt_q     <= ex_rt_d;
            mem_wb_q    <= mem_wb_d;
            mem_m_q     <= mem_m_d;
            wb_wb_q     <= wb_wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_wb      = ex_wb_q;
    assign ex_m       = ex_m_q;
    assign ex_ex      = ex_ex_q;
    assign ex_rt      = ex_rt_q;
    assign mem_wb     = mem_wb_q;
    assign mem_m      = mem_m_q;
    assign wb_wb      = wb_wb_q;
    assign illegal_op = dec_ill;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule
